// File: rtl/sprite_renderer.sv
// sprite_renderer: pipelined multi-sprite pixel generator with per-sprite texture RAM,
// shadow/active position config committed on FRAME_START, and fixed-priority mixing.
module sprite_renderer #(
    parameter int N_SPRITES = 4,
    parameter int W = 16,
    parameter int H = 16,
    parameter int CBITS = 1,
    parameter logic [3*CBITS-1:0] KEY = '0,
    parameter logic [3*CBITS-1:0] BG = '0,
    localparam int SW = (N_SPRITES > 1) ? $clog2(N_SPRITES) : 1,
    localparam int AW = $clog2(W * H)
) (
    input  logic               CLK,
    input  logic               reset,
    input  logic [9:0]         X_VGA,
    input  logic [9:0]         Y_VGA,
    input  logic               DE_IN,
    input  logic               FRAME_START,
    input  logic               CFG_WE,
    input  logic [SW-1:0]      CFG_SEL,
    input  logic [9:0]         CFG_X,
    input  logic [9:0]         CFG_Y,
    input  logic [1:0]         CFG_SCALE,
    input  logic               CFG_EN,
    input  logic               TEX_WE,
    input  logic [SW-1:0]      TEX_SEL,
    input  logic [AW-1:0]      TEX_ADDR,
    input  logic [3*CBITS-1:0] TEX_DATA,
    output logic [CBITS-1:0]   R_VGA,
    output logic [CBITS-1:0]   G_VGA,
    output logic [CBITS-1:0]   B_VGA,
    output logic               DE_OUT,
    output logic               HIT,
    output logic [SW-1:0]      HIT_ID
);
    localparam int WB = $clog2(W);
    localparam int HB = $clog2(H);
    localparam int TB = 3 * CBITS;

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        logic [1:0] scale;
        logic       en;
    } cfg_t;

    cfg_t              cfg_in;
    logic              in_w   [N_SPRITES];
    logic [AW-1:0]     addr_w [N_SPRITES];
    logic [AW-1:0]     addr1  [N_SPRITES];
    logic [TB-1:0]     texel  [N_SPRITES];
    logic [N_SPRITES-1:0] in1, in2;
    logic              de1, de2;
    logic [TB-1:0]     rgb_n;
    logic              hit_n;
    logic [SW-1:0]     id_n;

    assign cfg_in = {CFG_X, CFG_Y, CFG_SCALE, CFG_EN};

    for (genvar g = 0; g < N_SPRITES; g++) begin : g_spr
        cfg_t           sh, ac;
        logic           cfg_wr, tex_wr;
        logic [10:0]    dx, dy, x_end, y_end;
        logic [WB-1:0]  tx;
        logic [HB-1:0]  ty;
        logic [TB-1:0]  mem [W*H];
        assign cfg_wr = CFG_WE && CFG_SEL == SW'(g);
        assign tex_wr = TEX_WE && TEX_SEL == SW'(g);
        // a write landing on the commit edge goes straight into active as well
        always_ff @(posedge CLK) begin
            if (reset) begin
                sh <= '0;
                ac <= '0;
            end else begin
                if (cfg_wr) sh <= cfg_in;
                if (FRAME_START) ac <= cfg_wr ? cfg_in : sh;
            end
        end
        assign dx = {1'b0, X_VGA} - {1'b0, ac.x};
        assign dy = {1'b0, Y_VGA} - {1'b0, ac.y};
        assign x_end = {1'b0, ac.x} + (11'(W) << ac.scale);
        assign y_end = {1'b0, ac.y} + (11'(H) << ac.scale);
        assign tx = WB'(dx >> ac.scale);
        assign ty = HB'(dy >> ac.scale);
        assign in_w[g] = ac.en && X_VGA >= ac.x && {1'b0, X_VGA} < x_end
                         && Y_VGA >= ac.y && {1'b0, Y_VGA} < y_end;
        assign addr_w[g] = {ty, tx};
        always_ff @(posedge CLK) begin
            if (tex_wr) mem[TEX_ADDR] <= TEX_DATA;
            texel[g] <= mem[addr1[g]];
        end
    end

    always_ff @(posedge CLK) begin
        for (int i = 0; i < N_SPRITES; i++) addr1[i] <= addr_w[i];
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            de1 <= 1'b0;
            de2 <= 1'b0;
            in1 <= '0;
            in2 <= '0;
        end else begin
            de1 <= DE_IN;
            de2 <= de1;
            in2 <= in1;
            for (int i = 0; i < N_SPRITES; i++) in1[i] <= in_w[i];
        end
    end

    // scan from lowest priority upward so the lowest opaque index wins
    always_comb begin
        hit_n = 1'b0;
        id_n  = '0;
        rgb_n = BG;
        for (int i = N_SPRITES - 1; i >= 0; i--) begin
            if (in2[i] && texel[i] != KEY) begin
                hit_n = 1'b1;
                id_n  = SW'(i);
                rgb_n = texel[i];
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            DE_OUT <= 1'b0;
            HIT    <= 1'b0;
            HIT_ID <= '0;
            {R_VGA, G_VGA, B_VGA} <= '0;
        end else begin
            DE_OUT <= de2;
            HIT    <= de2 && hit_n;
            HIT_ID <= de2 ? id_n : '0;
            {R_VGA, G_VGA, B_VGA} <= de2 ? rgb_n : '0;
        end
    end
endmodule

// File: tb/tb_sprite_renderer.sv
// tb_sprite_renderer: scoreboard bench; a behavioural sprite model predicts every output cycle.
module tb_sprite_renderer;
    logic       CLK = 1'b0;
    logic       reset = 1'b1;
    logic [9:0] X_VGA = '0, Y_VGA = '0;
    logic       DE_IN = 1'b0, FRAME_START = 1'b0;
    logic       CFG_WE = 1'b0;
    logic [1:0] CFG_SEL = '0;
    logic [9:0] CFG_X = '0, CFG_Y = '0;
    logic [1:0] CFG_SCALE = '0;
    logic       CFG_EN = 1'b0;
    logic       TEX_WE = 1'b0;
    logic [1:0] TEX_SEL = '0;
    logic [7:0] TEX_ADDR = '0;
    logic [2:0] TEX_DATA = '0;
    logic       R_VGA, G_VGA, B_VGA, DE_OUT, HIT;
    logic [1:0] HIT_ID;

    sprite_renderer dut (
        .CLK(CLK), .reset(reset), .X_VGA(X_VGA), .Y_VGA(Y_VGA), .DE_IN(DE_IN),
        .FRAME_START(FRAME_START), .CFG_WE(CFG_WE), .CFG_SEL(CFG_SEL), .CFG_X(CFG_X),
        .CFG_Y(CFG_Y), .CFG_SCALE(CFG_SCALE), .CFG_EN(CFG_EN), .TEX_WE(TEX_WE),
        .TEX_SEL(TEX_SEL), .TEX_ADDR(TEX_ADDR), .TEX_DATA(TEX_DATA), .R_VGA(R_VGA),
        .G_VGA(G_VGA), .B_VGA(B_VGA), .DE_OUT(DE_OUT), .HIT(HIT), .HIT_ID(HIT_ID)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        logic [1:0] s;
        logic       en;
    } cfg_t;
    typedef struct packed {
        logic       de;
        logic       hit;
        logic [1:0] id;
        logic [2:0] rgb;
    } exp_t;

    cfg_t sh [4];
    cfg_t ac [4];
    logic [2:0] tex [4][256];
    exp_t q[$];
    int vecs = 0, errs = 0;

    logic       t_we = 1'b0, c_we = 1'b0, fs = 1'b0;
    logic [1:0] t_sel = '0, c_sel = '0, c_s = '0;
    logic [7:0] t_addr = '0;
    logic [2:0] t_dat = '0;
    logic [9:0] c_x = '0, c_y = '0;
    logic       c_en = 1'b0;

    task automatic chk(string tag, logic [7:0] got, logic [7:0] exp);
        vecs++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic exp_t model(bit de, int x, int y);
        exp_t e;
        e = '0;
        if (de) begin
            e.de = 1'b1;
            for (int i = 3; i >= 0; i--) begin
                int cx, cy, s, a;
                cx = int'(ac[i].x);
                cy = int'(ac[i].y);
                s = int'(ac[i].s);
                if (ac[i].en && x >= cx && x < cx + (16 << s) && y >= cy && y < cy + (16 << s)) begin
                    a = ((y - cy) >> s) * 16 + ((x - cx) >> s);
                    if (tex[i][a] != 3'b000) begin
                        e.hit = 1'b1;
                        e.id = 2'(i);
                        e.rgb = tex[i][a];
                    end
                end
            end
        end
        return e;
    endfunction

    task automatic step(bit de, int x, int y);
        exp_t e;
        @(negedge CLK);
        if (q.size() >= 3) begin
            e = q.pop_front();
            chk("de_out", 8'(DE_OUT), 8'(e.de));
            chk("hit", 8'(HIT), 8'(e.hit));
            chk("hit_id", 8'(HIT_ID), 8'(e.id));
            chk("rgb", 8'({R_VGA, G_VGA, B_VGA}), 8'(e.rgb));
        end
        DE_IN = de; X_VGA = 10'(x); Y_VGA = 10'(y);
        TEX_WE = t_we; TEX_SEL = t_sel; TEX_ADDR = t_addr; TEX_DATA = t_dat;
        CFG_WE = c_we; CFG_SEL = c_sel; CFG_X = c_x; CFG_Y = c_y; CFG_SCALE = c_s; CFG_EN = c_en;
        FRAME_START = fs;
        if (t_we) tex[t_sel][t_addr] = t_dat;
        q.push_back(model(de, x, y));
        if (c_we) sh[c_sel] = {c_x, c_y, c_s, c_en};
        if (fs) for (int i = 0; i < 4; i++) ac[i] = sh[i];
        t_we = 1'b0; c_we = 1'b0; fs = 1'b0;
    endtask

    task automatic tex_set(int sel, int addr, int d, bit de, int x, int y);
        t_we = 1'b1; t_sel = 2'(sel); t_addr = 8'(addr); t_dat = 3'(d);
        step(de, x, y);
    endtask

    task automatic cfg_set(int sel, int x, int y, int s, bit en, bit commit, bit de, int px, int py);
        c_we = 1'b1; c_sel = 2'(sel); c_x = 10'(x); c_y = 10'(y); c_s = 2'(s); c_en = en;
        fs = commit;
        step(de, px, py);
    endtask

    task automatic do_reset();
        @(negedge CLK);
        reset = 1'b1;
        DE_IN = 1'b0; TEX_WE = 1'b0; CFG_WE = 1'b0; FRAME_START = 1'b0;
        t_we = 1'b0; c_we = 1'b0; fs = 1'b0;
        for (int i = 0; i < 4; i++) begin
            sh[i] = '0;
            ac[i] = '0;
        end
        repeat (3) begin
            @(negedge CLK);
            chk("rst_de_out", 8'(DE_OUT), 8'h0);
            chk("rst_hit", 8'(HIT), 8'h0);
            chk("rst_hit_id", 8'(HIT_ID), 8'h0);
            chk("rst_rgb", 8'({R_VGA, G_VGA, B_VGA}), 8'h0);
        end
        reset = 1'b0;
        q.delete();
        repeat (3) q.push_back('0);
    endtask

    initial begin
        do_reset();
        step(1, 0, 0);
        step(0, 0, 0);
        for (int s = 0; s < 4; s++)
            for (int a = 0; a < 256; a++) tex_set(s, a, 0, 0, 0, 0);
        // sprite 0: single-scale, exclusive right/bottom edges
        tex_set(0, 0, 3'b100, 0, 0, 0);
        tex_set(0, 15, 3'b001, 0, 0, 0);
        cfg_set(0, 100, 50, 0, 1, 1, 0, 0, 0);
        step(1, 100, 50);
        step(1, 115, 50);
        step(1, 116, 50);
        step(1, 99, 50);
        step(1, 100, 65);
        step(1, 100, 66);
        step(0, 100, 50);
        // sprite 1: scale x4
        tex_set(1, 0, 3'b011, 0, 0, 0);
        tex_set(1, 1, 3'b010, 0, 0, 0);
        tex_set(1, 15, 3'b111, 0, 0, 0);
        cfg_set(1, 300, 200, 2, 1, 1, 0, 0, 0);
        for (int x = 303; x <= 307; x++) step(1, x, 200);
        step(1, 363, 200);
        step(1, 364, 200);
        // overlap of sprites 0 and 2
        tex_set(2, 0, 3'b110, 0, 0, 0);
        cfg_set(2, 100, 50, 0, 1, 1, 0, 0, 0);
        step(1, 100, 50);
        tex_set(0, 0, 3'b000, 0, 0, 0);
        step(1, 100, 50);
        step(1, 101, 50);
        // shadow write without commit, then commit, then same-edge write+commit
        cfg_set(0, 200, 50, 0, 1, 0, 1, 115, 50);
        step(1, 115, 50);
        step(1, 215, 50);
        fs = 1'b1;
        step(1, 115, 50);
        step(1, 215, 50);
        step(1, 115, 50);
        cfg_set(0, 400, 60, 0, 1, 1, 1, 415, 60);
        step(1, 415, 60);
        step(1, 215, 50);
        // clipping at the right screen edge
        for (int a = 0; a < 16; a++) tex_set(3, a, 3'b101, 0, 0, 0);
        cfg_set(3, 1020, 0, 0, 1, 1, 0, 0, 0);
        for (int x = 1016; x <= 1023; x++) step(1, x, 0);
        for (int x = 0; x <= 11; x++) step(1, x, 0);
        // same-address read/write on one edge returns old data
        step(1, 1020, 0);
        tex_set(3, 0, 3'b011, 1, 1020, 0);
        step(1, 1020, 0);
        for (int n = 0; n < 60; n++)
            step(1'($urandom_range(0, 1)), int'($urandom_range(90, 420)), int'($urandom_range(40, 280)));
        // reset mid-frame discards in-flight pixels and clears config
        step(1, 415, 60);
        step(1, 100, 50);
        do_reset();
        step(1, 0, 0);
        step(1, 415, 60);
        step(1, 300, 200);
        repeat (3) step(0, 0, 0);
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
